pc_unit: RTL and testbench

Parametrised program-counter unit for the single-cycle/pipelined MIPS core. It holds the fetch address and selects the next PC each cycle from sequential, branch, jump, return, exception and exception-return sources. It adds stall, exception entry/exit with an internal EPC, and an optional return-address stack. It sits at the head of the fetch stage and drives the instruction-memory address.

---
 rtl/pc_unit.sv | 150 +++++++++++++++
 tb/tb_pc_unit.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/pc_unit.sv
// pc_unit: program-counter unit at the head of the fetch stage.
// Holds the fetch address and picks the next PC from the exception, stall,
// eret, return, jump, branch and sequential sources. It also keeps the
// exception PC (epc) and the handler-active state.
// Optional feature: define PC_RAS_EN to build a circular return-address stack
// of RAS_DEPTH entries. jal pushes onto it and jr pops from it. Without the
// macro, ret always loads ret_target and jal is a plain jump.
module pc_unit #(
    parameter int unsigned     WIDTH      = 32,
    parameter logic [WIDTH-1:0] RESET_ADDR = WIDTH'(32'h0000_3000),
    parameter logic [WIDTH-1:0] EXC_VECTOR = WIDTH'(32'h0000_4180),
    parameter int unsigned     RAS_DEPTH  = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             stall,
    input  logic             br_taken,
    input  logic [WIDTH-1:0] br_target,
    input  logic             jump,
    input  logic             jump_link,
    input  logic [WIDTH-1:0] jump_target,
    input  logic             ret,
    input  logic [WIDTH-1:0] ret_target,
    input  logic             exc_req,
    input  logic             eret,
    output logic [WIDTH-1:0] pc,
    output logic [WIDTH-1:0] pc_plus4,
    output logic [WIDTH-1:0] epc,
    output logic             in_exc,
    output logic             misalign
);

    typedef enum logic [0:0] {
        StNormal  = 1'b0,
        StHandler = 1'b1
    } state_e;

    state_e           state_q, state_d;
    logic [WIDTH-1:0] pc_q, pc_d;
    logic [WIDTH-1:0] epc_q, epc_d;

    // Return-address stack interface, driven in both builds.
    logic             ras_push;
    logic             ras_pop;
    logic             ras_hit;
    logic [WIDTH-1:0] ras_top;

    assign pc       = pc_q;
    assign epc      = epc_q;
    assign in_exc   = (state_q == StHandler);
    // The sum wraps modulo 2^WIDTH.
    assign pc_plus4 = pc_q + WIDTH'(4);
    assign misalign = (pc_q[1:0] != 2'b00);

    // Next-PC selection in strict priority order. Only one source wins, so a push
    // and a pop never happen in the same cycle.
    always_comb begin
        pc_d     = pc_q;
        epc_d    = epc_q;
        state_d  = state_q;
        ras_push = 1'b0;
        ras_pop  = 1'b0;
        if (exc_req && (state_q == StNormal)) begin
            // An exception overrides a stall. Otherwise the redirect would be lost.
            pc_d    = EXC_VECTOR;
            epc_d   = pc_q;
            state_d = StHandler;
        end else if (stall) begin
            pc_d = pc_q;
        end else if (eret && (state_q == StHandler)) begin
            pc_d    = epc_q;
            state_d = StNormal;
        end else if (ret) begin
            if (ras_hit) begin
                pc_d    = ras_top;
                ras_pop = 1'b1;
            end else begin
                pc_d = ret_target;
            end
        end else if (jump) begin
            pc_d     = jump_target;
            ras_push = jump_link;
        end else if (br_taken) begin
            pc_d = br_target;
        end else begin
            pc_d = pc_plus4;
        end
    end

    // PC, EPC and the exception state all update on the same edge.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pc_q    <= RESET_ADDR;
            epc_q   <= '0;
            state_q <= StNormal;
        end else begin
            pc_q    <= pc_d;
            epc_q   <= epc_d;
            state_q <= state_d;
        end
    end

`ifdef PC_RAS_EN
    localparam int unsigned PTR_W = (RAS_DEPTH > 1) ? $clog2(RAS_DEPTH) : 1;
    localparam int unsigned CNT_W = $clog2(RAS_DEPTH + 1);

    logic [WIDTH-1:0] ras_mem [RAS_DEPTH];
    // ras_ptr_q points at the next slot to write. The top of the stack sits one below it.
    logic [PTR_W-1:0] ras_ptr_q;
    logic [PTR_W-1:0] ras_top_idx;
    logic [CNT_W-1:0] ras_cnt_q;

    assign ras_top_idx = ras_ptr_q - PTR_W'(1);
    assign ras_top     = ras_mem[ras_top_idx];
    assign ras_hit     = (ras_cnt_q != '0);

    // Stack storage needs no reset. An entry is read only while the count covers it.
    always_ff @(posedge clk) begin
        if (ras_push) begin
            ras_mem[ras_ptr_q] <= pc_plus4;
        end
    end

    // Circular pointer and saturating count. A push when full overwrites the oldest entry.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ras_ptr_q <= '0;
            ras_cnt_q <= '0;
        end else if (ras_push) begin
            ras_ptr_q <= ras_ptr_q + PTR_W'(1);
            if (ras_cnt_q != CNT_W'(RAS_DEPTH)) begin
                ras_cnt_q <= ras_cnt_q + CNT_W'(1);
            end
        end else if (ras_pop) begin
            ras_ptr_q <= ras_top_idx;
            ras_cnt_q <= ras_cnt_q - CNT_W'(1);
        end
    end
`else
    localparam int unsigned unused_ras_depth = RAS_DEPTH;

    assign ras_hit = 1'b0;
    assign ras_top = '0;

    // Without a stack, the push/pop strobes and jump_link have no consumer.
    logic unused_ras;
    assign unused_ras = ^{ras_push, ras_pop, jump_link};
`endif

endmodule

// File: tb/tb_pc_unit.sv
// Scoreboard bench for pc_unit. The driver pushes the hand-computed state
// expected after each edge (or after an asynchronous reset). A monitor pops
// and compares each entry when the DUT presents the new state.
module tb_pc_unit;

    logic        clk, rst;
    logic        stall, br_taken, jump, jump_link, ret, exc_req, eret;
    logic [31:0] br_target, jump_target, ret_target;
    logic [31:0] pc, pc_plus4, epc;
    logic        in_exc, misalign;

    typedef struct {
        string       name;
        logic [31:0] pc;
        logic [31:0] epc;
        logic        in_exc;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_pass   = 0;
    event async_chk;

`ifdef PC_RAS_EN
    logic [31:0] ret_exp [5] = '{32'h3014, 32'h3010, 32'h300C, 32'h3008, 32'hDEAD_0000};
    logic [31:0] ret_last_exp = 32'hDEAD_0004;
`else
    logic [31:0] ret_exp [5] = '{32'hDEAD_0000, 32'hDEAD_0000, 32'hDEAD_0000,
                                 32'hDEAD_0000, 32'hDEAD_0000};
    logic [31:0] ret_last_exp = 32'h3ABC;
`endif

    pc_unit dut (
        .clk         (clk),
        .rst         (rst),
        .stall       (stall),
        .br_taken    (br_taken),
        .br_target   (br_target),
        .jump        (jump),
        .jump_link   (jump_link),
        .jump_target (jump_target),
        .ret         (ret),
        .ret_target  (ret_target),
        .exc_req     (exc_req),
        .eret        (eret),
        .pc          (pc),
        .pc_plus4    (pc_plus4),
        .epc         (epc),
        .in_exc      (in_exc),
        .misalign    (misalign)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h, expected %h", nm, act, exp);
    endtask

    // Monitor: new state appears after each rising edge, or right after an async reset.
    initial begin
        forever begin
            exp_t e;
            @(posedge clk or async_chk);
            #1;
            if (sb.size() > 0) begin
                e = sb.pop_front();
                check({e.name, ".pc"}, pc, e.pc);
                check({e.name, ".pc_plus4"}, pc_plus4, e.pc + 32'd4);
                check({e.name, ".misalign"}, {31'd0, misalign}, {31'd0, e.pc[1:0] != 2'b00});
                check({e.name, ".epc"}, epc, e.epc);
                check({e.name, ".in_exc"}, {31'd0, in_exc}, {31'd0, e.in_exc});
            end
        end
    end

    task automatic drv(input bit s, input bit b, input bit j, input bit jl, input bit r,
                       input bit x, input bit er);
        stall     = s;
        br_taken  = b;
        jump      = j;
        jump_link = jl;
        ret       = r;
        exc_req   = x;
        eret      = er;
    endtask

    // Expectation for the next rising edge, then advance to the next falling edge.
    task automatic cyc(input string nm, input logic [31:0] p, input logic [31:0] e,
                       input logic x);
        sb.push_back('{nm, p, e, x});
        @(negedge clk);
    endtask

    initial begin
        rst         = 1'b0;
        br_target   = '0;
        jump_target = '0;
        ret_target  = '0;
        drv(0, 0, 0, 0, 0, 0, 0);

        cyc("rst_hold0", 32'h3000, 32'h0, 1'b0);
        cyc("rst_hold1", 32'h3000, 32'h0, 1'b0);
        rst = 1'b1;
        cyc("seq0", 32'h3004, 32'h0, 1'b0);
        cyc("seq1", 32'h3008, 32'h0, 1'b0);
        cyc("seq2", 32'h300C, 32'h0, 1'b0);
        cyc("seq3", 32'h3010, 32'h0, 1'b0);

        // Priority: jump beats branch. A stall holds everything except an exception.
        br_target   = 32'h3100;
        jump_target = 32'h3200;
        drv(0, 1, 1, 0, 0, 0, 0);
        cyc("br_vs_jump", 32'h3200, 32'h0, 1'b0);
        jump_target = 32'h3010;
        drv(0, 0, 1, 0, 0, 0, 0);
        cyc("jump_back", 32'h3010, 32'h0, 1'b0);
        jump_target = 32'h3200;
        drv(1, 1, 1, 0, 0, 0, 0);
        cyc("stall_hold", 32'h3010, 32'h0, 1'b0);
        drv(1, 1, 1, 0, 0, 1, 0);
        cyc("stall_exc", 32'h4180, 32'h3010, 1'b1);
        drv(0, 0, 0, 0, 0, 0, 1);
        cyc("eret0", 32'h3010, 32'h3010, 1'b0);

        // Exception round trip from 0x3020.
        drv(0, 0, 0, 0, 0, 0, 0);
        cyc("seq4", 32'h3014, 32'h3010, 1'b0);
        cyc("seq5", 32'h3018, 32'h3010, 1'b0);
        cyc("seq6", 32'h301C, 32'h3010, 1'b0);
        cyc("seq7", 32'h3020, 32'h3010, 1'b0);
        drv(0, 0, 0, 0, 0, 1, 0);
        cyc("exc_entry", 32'h4180, 32'h3020, 1'b1);
        cyc("exc_nested", 32'h4184, 32'h3020, 1'b1);
        drv(0, 0, 0, 0, 0, 0, 1);
        cyc("eret1", 32'h3020, 32'h3020, 1'b0);
        cyc("eret_normal", 32'h3024, 32'h3020, 1'b0);

        // Asynchronous reset asserted between edges.
        drv(0, 0, 0, 0, 0, 0, 0);
        sb.push_back('{"rst_async", 32'h3000, 32'h0, 1'b0});
        #2 rst = 1'b0;
        #1 -> async_chk;
        cyc("rst_held", 32'h3000, 32'h0, 1'b0);
        rst = 1'b1;
        cyc("rst_release", 32'h3004, 32'h0, 1'b0);

        // Address wrap and a misaligned target.
        jump_target = 32'hFFFF_FFFC;
        drv(0, 0, 1, 0, 0, 0, 0);
        cyc("wrap_pre", 32'hFFFF_FFFC, 32'h0, 1'b0);
        drv(0, 0, 0, 0, 0, 0, 0);
        cyc("wrap", 32'h0000_0000, 32'h0, 1'b0);
        jump_target = 32'h3002;
        drv(0, 0, 1, 0, 0, 0, 0);
        cyc("misalign", 32'h3002, 32'h0, 1'b0);
        drv(0, 0, 0, 0, 0, 0, 0);
        cyc("misalign_seq", 32'h3006, 32'h0, 1'b0);

        // Five calls, then five returns. The stack (if built) overflows once.
        jump_target = 32'h3000;
        drv(0, 0, 1, 0, 0, 0, 0);
        cyc("jump_base", 32'h3000, 32'h0, 1'b0);
        for (int i = 0; i < 5; i++) begin
            jump_target = 32'h3004 + 32'(4 * i);
            drv(0, 0, 1, 1, 0, 0, 0);
            cyc($sformatf("jal%0d", i), 32'h3004 + 32'(4 * i), 32'h0, 1'b0);
        end
        ret_target = 32'hDEAD_0000;
        for (int i = 0; i < 5; i++) begin
            drv(0, 0, 0, 0, 1, 0, 0);
            cyc($sformatf("ret%0d", i), ret_exp[i], 32'h0, 1'b0);
        end
        jump_target = 32'h3100;
        drv(0, 0, 1, 1, 0, 0, 0);
        cyc("jal_last", 32'h3100, 32'h0, 1'b0);
        ret_target = 32'h3ABC;
        drv(0, 0, 0, 0, 1, 0, 0);
        cyc("ret_last", ret_last_exp, 32'h0, 1'b0);

        drv(0, 0, 0, 0, 0, 0, 0);
        @(negedge clk);
        @(negedge clk);
        n_checks++;
        if (sb.size() == 0) n_pass++;
        else $display("FAIL scoreboard_drain: %0d entries left, expected 0", sb.size());

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
